// File: rtl/mips_bus_arbiter.sv
// mips_bus_arbiter
//
// Shares one Avalon-MM master port between a MIPS instruction-fetch port and a
// data port. One transaction is outstanding at a time. The winning request's
// address, data, byte lanes and direction are captured into the master output
// registers when it is granted. They are held there until the slave drops
// waitrequest. Completion returns read data on the owning port and raises a
// one-cycle done pulse for that port.
//
// Configuration macro:
//   ROUND_ROBIN_EN  - when defined, a tie between i_req and d_req goes to the
//                     port that was not granted last. When undefined, the data
//                     port always wins a tie.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   i_req, i_addr              instruction read request and byte address
//   i_rdata, i_done            instruction read data and completion pulse
//   d_req, d_write, d_addr,    data request, direction (1 = write), address,
//   d_wdata, d_byteenable      write data and byte lanes
//   d_rdata, d_done            data read data and completion pulse
//   address, write, read,      Avalon master command outputs (registered)
//   writedata, byteenable
//   waitrequest, readdata      Avalon slave response
//   owner                      grant holder (0 = instruction, 1 = data); valid while busy
//   busy                       high whenever a grant is active

module mips_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  // Instruction-fetch port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  // Data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  // Avalon-MM master
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  // Status
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantI = 2'd1,
    StGrantD = 2'd2
  } state_e;

  state_e      state_q, state_d;

  // The master command registers double as the latched request fields: they
  // are loaded once at grant time and only cleared on the return to idle.
  logic [31:0] address_q, address_d;
  logic        write_q, write_d;
  logic        read_q, read_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;

  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        owner_q, owner_d;
  logic        busy_q, busy_d;

`ifdef ROUND_ROBIN_EN
  // 1 = data port held the most recent grant.
  logic        last_d_q, last_d_d;
`endif

  // A port whose done is showing this cycle is still holding its request. It
  // must not win the edge that ends this cycle, or it would be reissued.
  logic i_elig;
  logic d_elig;
  logic pick_d;

  assign i_elig = i_req & ~i_done_q;
  assign d_elig = d_req & ~d_done_q;

`ifdef ROUND_ROBIN_EN
  assign pick_d = d_elig & (~i_elig | ~last_d_q);
`else
  assign pick_d = d_elig;
`endif

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    write_d      = write_q;
    read_d       = read_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    owner_d      = owner_q;
`ifdef ROUND_ROBIN_EN
    last_d_d     = last_d_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d      = StGrantD;
          address_d    = d_addr;
          writedata_d  = d_wdata;
          byteenable_d = d_byteenable;
          write_d      = d_write;
          read_d       = ~d_write;
          owner_d      = 1'b1;
`ifdef ROUND_ROBIN_EN
          last_d_d     = 1'b1;
`endif
        end else if (i_elig) begin
          state_d      = StGrantI;
          address_d    = i_addr;
          writedata_d  = 32'h0;
          byteenable_d = 4'b1111;
          write_d      = 1'b0;
          read_d       = 1'b1;
          owner_d      = 1'b0;
`ifdef ROUND_ROBIN_EN
          last_d_d     = 1'b0;
`endif
        end
      end

      StGrantI: begin
        if (!waitrequest) begin
          i_rdata_d    = readdata;
          i_done_d     = 1'b1;
          state_d      = StIdle;
          address_d    = 32'h0;
          writedata_d  = 32'h0;
          byteenable_d = 4'b0000;
          write_d      = 1'b0;
          read_d       = 1'b0;
        end
      end

      StGrantD: begin
        if (!waitrequest) begin
          // Writes leave the previous read data visible on d_rdata.
          if (!write_q) begin
            d_rdata_d = readdata;
          end
          d_done_d     = 1'b1;
          state_d      = StIdle;
          address_d    = 32'h0;
          writedata_d  = 32'h0;
          byteenable_d = 4'b0000;
          write_d      = 1'b0;
          read_d       = 1'b0;
        end
      end

      default: begin
        state_d      = StIdle;
        address_d    = 32'h0;
        writedata_d  = 32'h0;
        byteenable_d = 4'b0000;
        write_d      = 1'b0;
        read_d       = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      address_q    <= 32'h0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      writedata_q  <= 32'h0;
      byteenable_q <= 4'b0000;
      i_rdata_q    <= 32'h0;
      d_rdata_q    <= 32'h0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_d_q     <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      write_q      <= write_d;
      read_q       <= read_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
`ifdef ROUND_ROBIN_EN
      last_d_q     <= last_d_d;
`endif
    end
  end

  assign address    = address_q;
  assign write      = write_q;
  assign read       = read_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_done     = i_done_q;
  assign d_done     = d_done_q;
  assign owner      = owner_q;
  assign busy       = busy_q;

  a_no_read_and_write: assert property (@(posedge clk) disable iff (!reset) !(read && write));
  a_single_done:       assert property (@(posedge clk) disable iff (!reset) !(i_done && d_done));

endmodule

// File: tb/tb_mips_bus_arbiter.sv
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_write;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_rdata;
  logic        d_done;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        owner;
  logic        busy;

  always #5 clk = ~clk;

  // Slave model: read data is a fixed scramble of the address.
  // 0xBFC00000 maps to 0x24020005.
  localparam logic [31:0] RdKey = 32'h9BC2_0005;
  assign readdata = address ^ RdKey;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] model_d_rdata = 32'h0;

  mips_bus_arbiter u_dut (
    .clk          (clk),
    .reset        (reset),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .i_rdata      (i_rdata),
    .i_done       (i_done),
    .d_req        (d_req),
    .d_write      (d_write),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .d_byteenable (d_byteenable),
    .d_rdata      (d_rdata),
    .d_done       (d_done),
    .address      (address),
    .write        (write),
    .read         (read),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .waitrequest  (waitrequest),
    .readdata     (readdata),
    .owner        (owner),
    .busy         (busy)
  );

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    bus_t obs;
    bus_t exp;
    logic [31:0] e;
    if (reset) begin
      if (read && write) begin
        vectors++; errors++;
        $display("FAIL rw_overlap: read=%b write=%b, required not both high", read, write);
      end
      if ((read || write) && !waitrequest) begin
        obs.wr = write; obs.addr = address; obs.wdata = writedata; obs.be = byteenable;
        vectors++;
        if (bus_q.size() == 0) begin
          errors++;
          $display("FAIL bus_unexpected: got wr=%b addr=%h wdata=%h be=%b, required none",
                   obs.wr, obs.addr, obs.wdata, obs.be);
        end else begin
          exp = bus_q.pop_front();
          if (obs !== exp) begin
            errors++;
            $display("FAIL bus_txn: got wr=%b addr=%h wdata=%h be=%b, required wr=%b addr=%h wdata=%h be=%b",
                     obs.wr, obs.addr, obs.wdata, obs.be, exp.wr, exp.addr, exp.wdata, exp.be);
          end
        end
      end
      if (i_done) begin
        vectors++;
        if (i_exp_q.size() == 0) begin
          errors++;
          $display("FAIL i_done_unexpected: i_rdata=%h, required no i_done", i_rdata);
        end else begin
          e = i_exp_q.pop_front();
          if (i_rdata !== e) begin
            errors++;
            $display("FAIL i_rdata: got %h, required %h", i_rdata, e);
          end
        end
      end
      if (d_done) begin
        vectors++;
        if (d_exp_q.size() == 0) begin
          errors++;
          $display("FAIL d_done_unexpected: d_rdata=%h, required no d_done", d_rdata);
        end else begin
          e = d_exp_q.pop_front();
          if (d_rdata !== e) begin
            errors++;
            $display("FAIL d_rdata: got %h, required %h", d_rdata, e);
          end
        end
      end
    end
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_write = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_byteenable = 4'h0;
    waitrequest = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    model_d_rdata = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({read, write, address, writedata, byteenable} !== 70'h0) begin
      errors++;
      $display("FAIL reset_master: got rd=%b wr=%b addr=%h wd=%h be=%b, required all 0",
               read, write, address, writedata, byteenable);
    end
    vectors++;
    if ({busy, owner, i_done, d_done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got busy=%b owner=%b i_done=%b d_done=%b, required 0000",
               busy, owner, i_done, d_done);
    end
    vectors++;
    if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got i=%h d=%h, required 0/0", i_rdata, d_rdata);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      vectors++;
      if (busy !== 1'b0 || read !== 1'b0 || write !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: got busy=%b rd=%b wr=%b, required 0/0/0", busy, read, write);
      end
    end
  endtask

  task automatic test_fetch();
    bus_t b;
    b.wr = 1'b0; b.addr = 32'hBFC0_0000; b.wdata = 32'h0; b.be = 4'b1111;
    bus_q.push_back(b);
    i_exp_q.push_back(32'h2402_0005);
    waitrequest = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC0_0000;
    cyc();
    vectors++;
    if (read !== 1'b1 || write !== 1'b0 || address !== 32'hBFC0_0000 || byteenable !== 4'b1111
        || busy !== 1'b1 || owner !== 1'b0) begin
      errors++;
      $display("FAIL fetch_grant: got rd=%b wr=%b addr=%h be=%b busy=%b owner=%b, required 1 0 bfc00000 1111 1 0",
               read, write, address, byteenable, busy, owner);
    end
    cyc();
    vectors++;
    if (i_done !== 1'b1 || read !== 1'b0 || i_rdata !== 32'h2402_0005) begin
      errors++;
      $display("FAIL fetch_done: got i_done=%b rd=%b i_rdata=%h, required 1 0 24020005",
               i_done, read, i_rdata);
    end
    // i_req still high during the done cycle: must not be reissued.
    cyc();
    vectors++;
    if (i_done !== 1'b0 || busy !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("FAIL fetch_no_reissue: got i_done=%b busy=%b rd=%b, required 0 0 0",
               i_done, busy, read);
    end
    i_req = 1'b0;
    cyc();
  endtask

  task automatic test_data_read();
    bus_t b;
    b.wr = 1'b0; b.addr = 32'h0000_0040; b.wdata = 32'h1234_5678; b.be = 4'b0110;
    bus_q.push_back(b);
    model_d_rdata = 32'h0000_0040 ^ RdKey;
    d_exp_q.push_back(model_d_rdata);
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0040; d_wdata = 32'h1234_5678;
    d_byteenable = 4'b0110;
    cyc();
    vectors++;
    if (read !== 1'b1 || write !== 1'b0 || owner !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL dread_grant: got rd=%b wr=%b owner=%b busy=%b, required 1 0 1 1",
               read, write, owner, busy);
    end
    cyc();
    vectors++;
    if (d_done !== 1'b1 || i_done !== 1'b0) begin
      errors++;
      $display("FAIL dread_done: got d_done=%b i_done=%b, required 1 0", d_done, i_done);
    end
    cyc();
    vectors++;
    if (busy !== 1'b0 || d_done !== 1'b0) begin
      errors++;
      $display("FAIL dread_no_reissue: got busy=%b d_done=%b, required 0 0", busy, d_done);
    end
    d_req = 1'b0;
    cyc();
  endtask

  task automatic test_write_wait();
    bus_t b;
    int   ndone;
    b.wr = 1'b1; b.addr = 32'h0000_1000; b.wdata = 32'hDEAD_BEEF; b.be = 4'b0011;
    bus_q.push_back(b);
    d_exp_q.push_back(model_d_rdata);
    waitrequest = 1'b1;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_1000; d_wdata = 32'hDEAD_BEEF;
    d_byteenable = 4'b0011;
    ndone = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (d_done) ndone++;
      vectors++;
      if (write !== 1'b1 || read !== 1'b0 || address !== 32'h0000_1000
          || writedata !== 32'hDEAD_BEEF || byteenable !== 4'b0011) begin
        errors++;
        $display("FAIL write_hold[%0d]: got wr=%b rd=%b addr=%h wd=%h be=%b, required 1 0 00001000 deadbeef 0011",
                 k, write, read, address, writedata, byteenable);
      end
      if (k == 3) waitrequest = 1'b0;
    end
    cyc();
    if (d_done) ndone++;
    vectors++;
    if (d_done !== 1'b1 || write !== 1'b0 || read !== 1'b0 || d_rdata !== model_d_rdata) begin
      errors++;
      $display("FAIL write_done: got d_done=%b wr=%b rd=%b d_rdata=%h, required 1 0 0 %h",
               d_done, write, read, d_rdata, model_d_rdata);
    end
    cyc();
    if (d_done) ndone++;
    d_req = 1'b0;
    cyc();
    vectors++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL write_done_count: got %0d pulses, required 1", ndone);
    end
  endtask

  task automatic test_tie();
    bus_t b;
    int   ni;
    int   nd;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
`ifdef ROUND_ROBIN_EN
      b.wr = 1'b0; b.addr = 32'h100 + 32'(4 * k); b.wdata = 32'h0; b.be = 4'hF;
      bus_q.push_back(b);
      b.addr = 32'h2000 + 32'(4 * k);
      bus_q.push_back(b);
`else
      b.wr = 1'b0; b.addr = 32'h2000 + 32'(4 * k); b.wdata = 32'h0; b.be = 4'hF;
      bus_q.push_back(b);
      b.addr = 32'h100 + 32'(4 * k);
      bus_q.push_back(b);
`endif
      i_exp_q.push_back((32'h100 + 32'(4 * k)) ^ RdKey);
      d_exp_q.push_back((32'h2000 + 32'(4 * k)) ^ RdKey);
    end
    ni = 0; nd = 0;
    waitrequest = 1'b0;
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0; d_byteenable = 4'hF;
    cyc();
    vectors++;
`ifdef ROUND_ROBIN_EN
    if (owner !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tie_first: got owner=%b busy=%b, required 0 1", owner, busy);
    end
`else
    if (owner !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tie_first: got owner=%b busy=%b, required 1 1", owner, busy);
    end
`endif
    for (int c = 0; c < 60 && (ni < 4 || nd < 4); c++) begin
      cyc();
      if (i_done) begin
        ni++;
        if (ni == 4) i_req = 1'b0;
        else i_addr = 32'h100 + 32'(4 * ni);
      end
      if (d_done) begin
        nd++;
        if (nd == 4) d_req = 1'b0;
        else d_addr = 32'h2000 + 32'(4 * nd);
      end
    end
    vectors++;
    if (ni != 4 || nd != 4) begin
      errors++;
      $display("FAIL tie_progress: got i=%0d d=%0d completions, required 4 4", ni, nd);
    end
    model_d_rdata = (32'h2000 + 32'd12) ^ RdKey;
    cyc();
    cyc();
  endtask

  task automatic test_reset_mid();
    waitrequest = 1'b1;
    d_req = 1'b1; d_write = 1'b1; d_addr = 32'h0000_3000; d_wdata = 32'hCAFE_F00D;
    d_byteenable = 4'hF;
    cyc();
    vectors++;
    if (write !== 1'b1 || busy !== 1'b1 || owner !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_grant: got wr=%b busy=%b owner=%b, required 1 1 1", write, busy, owner);
    end
    cyc();
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (write !== 1'b0 || read !== 1'b0 || busy !== 1'b0 || address !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: got wr=%b rd=%b busy=%b addr=%h, required 0 0 0 0",
               write, read, busy, address);
    end
    d_req = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    waitrequest = 1'b0;
    model_d_rdata = 32'h0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      vectors++;
      if (d_done !== 1'b0 || busy !== 1'b0 || write !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_after[%0d]: got d_done=%b busy=%b wr=%b, required 0 0 0",
                 k, d_done, busy, write);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_fetch();
    test_data_read();
    test_write_wait();
    test_tie();
    test_reset_mid();
    vectors++;
    if (bus_q.size() != 0 || i_exp_q.size() != 0 || d_exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got bus=%0d i=%0d d=%0d pending, required 0 0 0",
               bus_q.size(), i_exp_q.size(), d_exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-003 SHALL: i_req  input  1  instruction-fetch port read request.
REQ-004 SHALL: i_addr  input  32  instruction-fetch byte address.
REQ-005 SHALL: i_rdata  output  32  instruction read data.
REQ-006 SHALL: i_done  output  1  one-cycle pulse marking instruction transaction complete.
REQ-007 SHALL: d_req  input  1  data port request.
REQ-008 SHALL: d_write  input  1  data port direction; 1 = write, 0 = read.
REQ-009 SHALL: d_addr  input  32  data port byte address.
REQ-010 SHALL: d_wdata  input  32  data port write data.
REQ-011 SHALL: d_byteenable  input  4  data port byte lanes.
REQ-012 SHALL: d_rdata  output  32  data port read data.
REQ-013 SHALL: d_done  output  1  one-cycle pulse marking data transaction complete.
REQ-014 SHALL: address, write, read, writedata, byteenable  output  32/1/1/32/4  Avalon master signals.
REQ-015 SHALL: waitrequest, readdata  input  1/32  Avalon slave response.
REQ-016 SHALL: owner  output  1  current grant holder; 0 = instruction, 1 = data; valid only while busy=1.
REQ-017 SHALL: busy  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL: FSM states are IDLE, GRANT_I and GRANT_D; all outputs are registered.
REQ-019 SHALL: in IDLE, sample i_req/d_req at posedge; on a winner, latch its address, data, byteenable and direction into registers, then enter GRANT_I or GRANT_D.
REQ-020 SHALL: GRANT_I drives read=1, write=0, byteenable=4'b1111 and the latched i_addr.
REQ-021 SHALL: GRANT_D drives the latched d_addr, d_wdata and d_byteenable, with read=~d_write and write=d_write.
REQ-022 SHALL: never assert read and write in the same cycle; in IDLE, drive read, write, address, writedata and byteenable to 0.
REQ-023 SHALL: hold all master outputs stable while waitrequest=1; the grant state persists indefinitely.
REQ-024 SHALL: on a posedge in a grant state with waitrequest=0, capture readdata into i_rdata or d_rdata (reads only), pulse the matching done for the following cycle, and return to IDLE.
REQ-025 SHALL: minimum latency from req sampled to done asserted is 2 cycles; at most one transaction is outstanding.
REQ-026 SHALL: i_rdata and d_rdata hold their value until the next read completion on that port; writes leave d_rdata unchanged.
REQ-027 SHALL: a requester holds its req and fields until its done; deasserting req mid-grant does not abort the transaction.
REQ-028 SHALL: a port whose done is high in a cycle is excluded from arbitration at that cycle's edge, preventing reissue.
REQ-029 SHALL: with no request in IDLE, remain in IDLE.

Reset
REQ-030 SHALL: while reset=0, immediately (asynchronously) force state to IDLE and all outputs, latched fields and rdata registers to 0, and set the round-robin last-grant flag to data (1).
REQ-031 SHALL: reset asserted mid-transaction abandons it; no done pulse is generated, and the bus is idle on the first cycle after release.

Configuration
REQ-032 SHALL: macro ROUND_ROBIN_EN selects the tie-break rule for simultaneous i_req and d_req.
REQ-033 SHALL: with ROUND_ROBIN_EN defined, the port not granted last wins a tie, and the last-grant flag updates on every grant.
REQ-034 SHALL: without ROUND_ROBIN_EN, data wins every tie (fixed priority), and the last-grant flag is not implemented.

Verification
REQ-035 SHALL: i_req, i_addr=0xBFC00000, waitrequest=0, readdata=0x24020005 -> read=1 at 0xBFC00000 with byteenable=1111; i_done pulses 2 cycles after req; i_rdata=0x24020005.
REQ-036 SHALL: d_req write to 0x00001000, wdata=0xDEADBEEF, byteenable=0011, waitrequest high for 3 cycles -> write/address/writedata held constant for 4 cycles, one d_done pulse, read never high.
REQ-037 SHALL: i_req and d_req together from reset, without macro -> data granted first, then instruction; with ROUND_ROBIN_EN -> instruction first, then data, then alternation over repeated ties.
REQ-038 SHALL: requester keeps req high during its done cycle -> no second transaction issued for that port at that edge.
REQ-039 SHALL: reset pulled low during GRANT_D with waitrequest=1 -> read/write drop to 0 asynchronously, busy=0, no d_done after release.
